multi_channel_rate_counter: RTL and testbench

Parametrised successor to the single-channel laser-rate counter. It measures the edge rate of CHANNELS asynchronous pulse inputs over a common, runtime-programmable gate window. Each input has its own synchroniser, and edge polarity is selectable. Accumulators saturate and report overflow. All channel results are latched together at the end of each window with a one-cycle valid strobe, for readout by the Ethernet register map.

---
 rtl/multi_channel_rate_counter.sv | 125 ++++++++++++
 tb/tb_multi_channel_rate_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_rate_counter.sv
// Multi-channel pulse rate counter: per-channel synchronised edge counting
// over a shared programmable gate window, with saturating accumulators.
module multi_channel_rate_counter #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int CLK_RATE    = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic                      Enable,
    input  logic [1:0]                EdgeSel,
    input  logic [31:0]               GateCycles,
    input  logic [CHANNELS-1:0]       Pulse,
    output logic [CHANNELS*CNT_W-1:0] Rate,
    output logic [CHANNELS-1:0]       Overflow,
    output logic                      RateValid
);

    localparam int          SW       = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SUP_INIT = SW'(SYNC_STAGES + 1);
    localparam logic [31:0] CLK_G    = 32'(CLK_RATE);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  hist_q;
    logic [SW-1:0]                        sup_q, sup_d;
    logic [31:0]                          cnt_q, cnt_d;
    logic [31:0]                          g_q, g_d;
    logic [CHANNELS-1:0][CNT_W-1:0]       acc_q, acc_d, acc_n;
    logic [CHANNELS-1:0]                  sat_q, sat_d, sat_n;
    logic [CHANNELS-1:0][CNT_W-1:0]       rate_q, rate_d;
    logic [CHANNELS-1:0]                  ovf_q, ovf_d;
    logic                                 valid_q, valid_d;

    logic [CHANNELS-1:0] synced, rise, fall, evt_raw, evt;
    logic [31:0]         gate_now, g_eff;
    logic                terminal, det_en;

    always_comb begin
        synced   = sync_q[SYNC_STAGES-1];
        rise     = synced & ~hist_q;
        fall     = ~synced & hist_q;
        evt_raw  = rise;
        unique case (EdgeSel)
            2'b01:   evt_raw = fall;
            2'b10:   evt_raw = rise | fall;
            default: evt_raw = rise;
        endcase
        det_en   = Enable && (sup_q == '0);
        evt      = det_en ? evt_raw : '0;
        // The window length is only sampled on its first cycle.
        gate_now = (GateCycles == '0) ? CLK_G : GateCycles;
        g_eff    = (cnt_q == '0) ? gate_now : g_q;
        terminal = Enable && (cnt_q == g_eff - 32'd1);
    end

    always_comb begin
        acc_n = acc_q;
        sat_n = sat_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (evt[i]) begin
                if (&acc_q[i]) begin
                    sat_n[i] = 1'b1;
                end else begin
                    acc_n[i] = acc_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q + 32'd1;
        acc_d   = acc_n;
        sat_d   = sat_n;
        rate_d  = rate_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        g_d     = (cnt_q == '0) ? gate_now : g_q;
        sup_d   = (sup_q != '0) ? sup_q - SW'(1) : sup_q;
        if (!Enable) begin
            cnt_d = '0;
            acc_d = '0;
            sat_d = '0;
            sup_d = SUP_INIT;
        end else if (terminal) begin
            cnt_d   = '0;
            acc_d   = '0;
            sat_d   = '0;
            rate_d  = acc_n;
            ovf_d   = sat_n;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sync_q  <= '0;
            hist_q  <= '0;
            sup_q   <= SUP_INIT;
            cnt_q   <= '0;
            g_q     <= '0;
            acc_q   <= '0;
            sat_q   <= '0;
            rate_q  <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], Pulse};
            hist_q  <= synced;
            sup_q   <= sup_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            rate_q  <= rate_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign Rate      = rate_q;
    assign Overflow  = ovf_q;
    assign RateValid = valid_q;

endmodule

// File: tb/tb_multi_channel_rate_counter.sv
// Directed scoreboard bench for multi_channel_rate_counter
// (4 channels, 4-bit accumulators, CLK_RATE = 64).
module tb_multi_channel_rate_counter;

    localparam int CH = 4;
    localparam int CW = 4;

    localparam int M_IDLE = 0;
    localparam int M_P10  = 1;
    localparam int M_CH1  = 2;
    localparam int M_TOG  = 3;
    localparam int M_SQ   = 4;
    localparam int M_G1   = 5;
    localparam int M_HI   = 6;
    localparam int M_HOLD = 7;
    localparam int M_TWO  = 8;
    localparam int M_GCH  = 9;

    typedef struct {
        logic [CH*CW-1:0] rate;
        logic [CH-1:0]    ovf;
        int               cyc;
    } exp_t;

    logic              Clk;
    logic              nReset;
    logic              Enable;
    logic [1:0]        EdgeSel;
    logic [31:0]       GateCycles;
    logic [CH-1:0]     Pulse;
    logic [CH*CW-1:0]  Rate;
    logic [CH-1:0]     Overflow;
    logic              RateValid;

    exp_t             sb[$];
    int               nvec = 0;
    int               nmis = 0;
    logic [CH*CW-1:0] last_rate = '0;
    logic [CH-1:0]    last_ovf = '0;
    int               sum1 = 0;
    int               edges1 = 0;

    multi_channel_rate_counter #(
        .CHANNELS(CH),
        .CNT_W(CW),
        .CLK_RATE(64),
        .SYNC_STAGES(2)
    ) dut (
        .Clk(Clk),
        .nReset(nReset),
        .Enable(Enable),
        .EdgeSel(EdgeSel),
        .GateCycles(GateCycles),
        .Pulse(Pulse),
        .Rate(Rate),
        .Overflow(Overflow),
        .RateValid(RateValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH*CW-1:0] rv(input int v0, input int v1,
                                            input int v2, input int v3);
        return {4'(v3), 4'(v2), 4'(v1), 4'(v0)};
    endfunction

    function automatic logic [CH-1:0] pat(input int mode, input int c);
        logic [CH-1:0] p;
        int            r;
        p = '0;
        r = c % 100;
        case (mode)
            M_P10:  p[0] = (c % 10) >= 5;
            M_CH1:  p[1] = (c < 300) &&
                           ((r >= 20 && r <= 22) || (r >= 40 && r <= 42) ||
                            (r >= 60 && r <= 62) || (r >= 80 && r <= 82) ||
                            (r >= 97 && r <= 99));
            M_TOG:  p[2] = (c < 48) ? ((c % 2) == 1) : 1'b1;
            M_SQ:   p[3] = (c % 20) >= 10;
            M_G1:   p[0] = (c >= 5 && c <= 7) || (c >= 10 && c <= 12);
            M_HI:   p[0] = c >= 5;
            M_HOLD: p[0] = 1'b1;
            M_TWO:  p[0] = (c >= 5 && c <= 7) || (c >= 25 && c <= 27);
            default: p = '0;
        endcase
        return p;
    endfunction

    task automatic push(input logic [CH*CW-1:0] r, input logic [CH-1:0] o,
                        input int cyc);
        exp_t e;
        e.rate = r;
        e.ovf  = o;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic start(input int g, input logic [1:0] es);
        GateCycles = 32'(g);
        EdgeSel    = es;
        Enable     = 1'b1;
    endtask

    task automatic run(input string tag, input int mode, input int n);
        exp_t          e;
        logic [CH-1:0] prev;
        for (int c = 0; c < n; c++) begin
            if (RateValid === 1'b1) begin
                nvec++;
                assert (sb.size() > 0) else begin
                    nmis++;
                    $error("FAIL %s_unexpected_valid observed=cycle %0d expected=none",
                           tag, c);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, "_rate"}, 32'(Rate), 32'(e.rate));
                    chk({tag, "_ovf"}, 32'(Overflow), 32'(e.ovf));
                    chk({tag, "_cycle"}, 32'(c), 32'(e.cyc));
                    last_rate = e.rate;
                    last_ovf  = e.ovf;
                    sum1 += int'(Rate[CW +: CW]);
                end
            end
            if (mode == M_GCH && c == 30) GateCycles = 32'd40;
            prev  = Pulse;
            Pulse = pat(mode, c);
            if (Pulse[1] && !prev[1]) edges1++;
            @(negedge Clk);
        end
        chk({tag, "_missing"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic idle(input int n);
        Enable = 1'b0;
        Pulse  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            chk("idle_valid", 32'(RateValid), 32'd0);
            chk("idle_rate", 32'(Rate), 32'(last_rate));
            chk("idle_ovf", 32'(Overflow), 32'(last_ovf));
        end
    endtask

    initial begin
        nReset     = 1'b0;
        Enable     = 1'b0;
        EdgeSel    = 2'b00;
        GateCycles = 32'd0;
        Pulse      = '0;
        repeat (3) @(negedge Clk);
        chk("reset_rate", 32'(Rate), 32'd0);
        chk("reset_ovf", 32'(Overflow), 32'd0);
        chk("reset_valid", 32'(RateValid), 32'd0);
        nReset = 1'b1;
        idle(5);

        start(100, 2'b00);
        push(rv(10, 0, 0, 0), 4'b0000, 100);
        push(rv(10, 0, 0, 0), 4'b0000, 200);
        run("p10", M_P10, 201);
        idle(6);

        start(0, 2'b00);
        push(rv(6, 0, 0, 0), 4'b0000, 64);
        push(rv(7, 0, 0, 0), 4'b0000, 128);
        run("clkrate", M_P10, 129);
        idle(6);

        sum1   = 0;
        edges1 = 0;
        start(100, 2'b00);
        push(rv(0, 5, 0, 0), 4'b0000, 100);
        push(rv(0, 5, 0, 0), 4'b0000, 200);
        push(rv(0, 5, 0, 0), 4'b0000, 300);
        run("term_edge", M_CH1, 301);
        chk("ch1_sum_vs_driven", 32'(sum1), 32'(edges1));
        idle(6);

        start(50, 2'b10);
        push(rv(0, 0, 15, 0), 4'b0100, 50);
        push(rv(0, 0, 0, 0), 4'b0000, 100);
        run("saturate", M_TOG, 101);
        idle(6);

        start(100, 2'b10);
        push(rv(0, 0, 0, 9), 4'b0000, 100);
        push(rv(0, 0, 0, 10), 4'b0000, 200);
        run("sq_both", M_SQ, 201);
        idle(6);
        start(100, 2'b01);
        push(rv(0, 0, 0, 4), 4'b0000, 100);
        push(rv(0, 0, 0, 5), 4'b0000, 200);
        run("sq_fall", M_SQ, 201);
        idle(6);
        start(100, 2'b11);
        push(rv(0, 0, 0, 5), 4'b0000, 100);
        push(rv(0, 0, 0, 5), 4'b0000, 200);
        run("sq_rise11", M_SQ, 201);
        idle(6);

        start(100, 2'b00);
        push(rv(0, 0, 0, 0), 4'b0000, 100);
        push(rv(0, 0, 0, 0), 4'b0000, 140);
        push(rv(0, 0, 0, 0), 4'b0000, 180);
        run("gate_change", M_GCH, 181);
        idle(6);

        start(1, 2'b00);
        for (int k = 1; k <= 15; k++) begin
            push(rv((k == 8 || k == 13) ? 1 : 0, 0, 0, 0), 4'b0000, k);
        end
        run("g1", M_G1, 16);
        idle(6);

        start(20, 2'b00);
        push(rv(1, 0, 0, 0), 4'b0000, 20);
        run("pre_reset", M_HI, 31);
        nReset = 1'b0;
        #1;
        chk("async_rst_rate", 32'(Rate), 32'd0);
        chk("async_rst_ovf", 32'(Overflow), 32'd0);
        chk("async_rst_valid", 32'(RateValid), 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        push(rv(0, 0, 0, 0), 4'b0000, 20);
        run("post_reset", M_HOLD, 21);
        idle(6);

        start(20, 2'b00);
        push(rv(1, 0, 0, 0), 4'b0000, 20);
        run("pre_disable", M_TWO, 31);
        idle(40);
        start(20, 2'b00);
        push(rv(0, 0, 0, 0), 4'b0000, 20);
        run("re_enable", M_IDLE, 21);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
